// File: rtl/pipeline_stage_reg.sv
// pipeline_stage_reg
// Flow-controlled pipeline stage register with a 2-entry skid buffer and
// stall / bubble / flush controls. It carries a WIDTH-bit payload between two
// pipeline stages using a valid/ready handshake. in_ready depends only on the
// stored state and control_signal, so it does not depend on out_ready.
//
// Parameters:
//   WIDTH       payload width in bits (1..128)
//   RESET_DATA  value shown on out_data after reset and after a flush
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   control_signal  00 transfer, 01 stall, 10 bubble, 11 flush
//   in_valid        upstream payload valid
//   in_data         upstream payload
//   in_ready        stage can accept this cycle
//   out_valid       downstream payload valid
//   out_data        downstream payload (main entry)
//   out_ready       downstream accepts this cycle
//   stall_count     saturating count of edges with data held but not drained
//                   (present only when PIPE_STAGE_STATS_EN is defined)
//
// Optional feature macro: PIPE_STAGE_STATS_EN

module pipeline_stage_reg #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       control_signal,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [15:0]      stall_count
`endif
);

  localparam logic [1:0] CtlTransfer = 2'b00;
  localparam logic [1:0] CtlStall    = 2'b01;
  localparam logic [1:0] CtlFlush    = 2'b11;

  // Occupancy: StOne holds the main entry only, StFull holds main + skid.
  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;

  logic main_valid;
  logic skid_valid;
  logic accept;
  logic drain;

  assign main_valid = (state_q != StEmpty);
  assign skid_valid = (state_q == StFull);

  assign in_ready  = !skid_valid && (control_signal == CtlTransfer);
  assign out_valid = main_valid && (control_signal != CtlStall);
  assign out_data  = main_data_q;

  // in_ready already excludes stall, bubble and flush, and out_valid excludes
  // stall, so both controls fall out of the transfer rules below.
  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (control_signal == CtlFlush) begin
      // Held data and same-cycle input are both discarded.
      state_d     = StEmpty;
      main_data_d = RESET_DATA;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d     = StOne;
            main_data_d = in_data;
          end
        end
        StOne: begin
          if (accept && drain) begin
            main_data_d = in_data;
          end else if (accept) begin
            state_d     = StFull;
            skid_data_d = in_data;
          end else if (drain) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          // No accept is possible here; the skid entry moves up on a drain.
          if (drain) begin
            state_d     = StOne;
            main_data_d = skid_data_q;
          end
        end
        default: begin
          state_d = StEmpty;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      main_data_q <= RESET_DATA;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (main_valid && !drain && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Self-checking bench for pipeline_stage_reg. A queue-based model of the
// stage's occupancy predicts in_ready, out_valid, out_data (and stall_count
// when PIPE_STAGE_STATS_EN is defined) on every cycle; a few literal checks
// pin the model to hand-computed values.

module tb_pipeline_stage_reg;

  localparam int unsigned W     = 32;
  localparam logic [31:0] RDATA = 32'h0BAD_F00D;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    control_signal;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
`ifdef PIPE_STAGE_STATS_EN
  logic [15:0]   stall_count;
`endif

  pipeline_stage_reg #(
    .WIDTH      (W),
    .RESET_DATA (RDATA)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .control_signal (control_signal),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_count    (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: the stage is a FIFO of at most two payloads.
  logic [31:0] q[$];
  bit          model_ok = 1'b0;
  bit          fresh    = 1'b0;   // out_data known to be RDATA
  int unsigned exp_cnt  = 0;
  bit          last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance model.
  task automatic step(input bit r, input logic [1:0] cs, input bit iv,
                      input logic [31:0] id, input bit ordy);
    bit exp_ir, exp_ov, drn;
    rst = r; control_signal = cs; in_valid = iv; in_data = id; out_ready = ordy;
    @(negedge clk);
    exp_ir = (q.size() < 2) && (cs == 2'b00);
    exp_ov = (q.size() > 0) && (cs != 2'b01);
    if (model_ok) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ir});
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
      if (q.size() > 0) chk("out_data", out_data, q[0]);
      else if (fresh) chk("out_data_reset", out_data, RDATA);
`ifdef PIPE_STAGE_STATS_EN
      chk("stall_count", {16'b0, stall_count}, exp_cnt);
`endif
    end
    last_acc = iv && exp_ir && !r;
    drn      = exp_ov && ordy;
    @(posedge clk);
    if (r) begin
      q.delete();
      fresh    = 1'b1;
      exp_cnt  = 0;
      model_ok = 1'b1;
    end else begin
      if (q.size() > 0 && !drn && exp_cnt < 16'hFFFF) exp_cnt++;
      if (cs == 2'b11) begin
        q.delete();
        fresh = 1'b1;
      end else begin
        if (drn) void'(q.pop_front());
        if (last_acc) begin
          q.push_back(id);
          fresh = 1'b0;
        end
      end
    end
    #1;
  endtask

  logic [31:0] pend_data;
  bit          pend_valid;
  int unsigned rv;
  logic [1:0]  rcs;

  initial begin
    // Reset
    step(1, 2'b00, 0, 0, 1);
    step(1, 2'b00, 0, 0, 1);
    chk("lit_reset_data", out_data, RDATA);
    step(0, 2'b00, 0, 0, 1);

    // Streaming at full throughput
    step(0, 2'b00, 1, 32'hA5A5A5A5, 1);
    chk("lit_first_push", out_data, 32'hA5A5A5A5);
    step(0, 2'b00, 1, 32'h00000001, 1);
    chk("lit_second_push", out_data, 32'h00000001);
    step(0, 2'b00, 1, 32'h00000002, 1);
    step(0, 2'b00, 0, 0, 1);
    step(0, 2'b00, 0, 0, 1);

    // Back-pressure fills the skid; 33 must wait
    step(0, 2'b00, 1, 32'h11, 0);
    step(0, 2'b00, 1, 32'h22, 0);
    chk("lit_model_full", q.size(), 2);
    chk("lit_main_11", out_data, 32'h11);
    step(0, 2'b00, 1, 32'h33, 0);
    chk("lit_33_refused", {31'b0, last_acc}, 0);
    step(0, 2'b00, 1, 32'h33, 1);
    chk("lit_drain_to_22", out_data, 32'h22);
    step(0, 2'b00, 1, 32'h33, 1);
    chk("lit_accept_33", out_data, 32'h33);
    step(0, 2'b00, 0, 0, 1);
    chk("lit_empty", q.size(), 0);

    // Stall while FULL
    step(0, 2'b00, 1, 32'h11, 0);
    step(0, 2'b00, 1, 32'h22, 0);
    for (int i = 0; i < 3; i++) step(0, 2'b01, 0, 0, 1);
    chk("lit_stall_hold", out_data, 32'h11);
    step(0, 2'b00, 0, 0, 1);
    chk("lit_after_stall", out_data, 32'h22);
    step(0, 2'b00, 0, 0, 1);

    // Bubbles in a stream
    step(0, 2'b00, 1, 32'h101, 1);
    step(0, 2'b00, 1, 32'h102, 1);
    step(0, 2'b10, 1, 32'h103, 1);
    step(0, 2'b10, 1, 32'h103, 1);
    step(0, 2'b00, 1, 32'h103, 1);
    chk("lit_after_bubble", out_data, 32'h103);
    step(0, 2'b00, 1, 32'h104, 1);
    step(0, 2'b00, 0, 0, 1);

    // Flush while FULL
    step(0, 2'b00, 1, 32'h11, 0);
    step(0, 2'b00, 1, 32'h22, 0);
    step(0, 2'b11, 1, 32'h99, 1);
    chk("lit_flush_data", out_data, RDATA);
    step(0, 2'b00, 0, 0, 0);

    // Reset mid-stream
    step(0, 2'b00, 1, 32'h44, 0);
    step(0, 2'b00, 1, 32'h55, 0);
    step(1, 2'b00, 1, 32'h66, 1);
    chk("lit_rst_data", out_data, RDATA);
    step(0, 2'b00, 0, 0, 1);

    // Randomized traffic; upstream holds a payload until it is accepted
    pend_valid = 1'b0;
    pend_data  = '0;
    for (int i = 0; i < 600; i++) begin
      if (!pend_valid && ($urandom_range(0, 3) != 0)) begin
        pend_valid = 1'b1;
        pend_data  = $urandom;
      end
      rv = $urandom_range(0, 11);
      rcs = (rv < 7) ? 2'b00 : (rv < 9) ? 2'b01 : (rv < 11) ? 2'b10 : 2'b11;
      step(($urandom_range(0, 99) == 0), rcs, pend_valid, pend_data,
           ($urandom_range(0, 2) != 0));
      if (last_acc) pend_valid = 1'b0;
    end
    step(0, 2'b00, 0, 0, 1);
    step(0, 2'b00, 0, 0, 1);

`ifdef PIPE_STAGE_STATS_EN
    // Saturation of the stall counter
    step(1, 2'b00, 0, 0, 0);
    chk("lit_cnt_reset", {16'b0, stall_count}, 0);
    step(0, 2'b00, 1, 32'h77, 0);
    for (int i = 0; i < 70000; i++) step(0, 2'b00, 0, 0, 0);
    chk("lit_cnt_sat", {16'b0, stall_count}, 32'h0000FFFF);
    step(1, 2'b00, 0, 0, 0);
    chk("lit_cnt_cleared", {16'b0, stall_count}, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
